// File: rtl/instr_issue_q.sv
// ---------------------------------------------------------------------------
// instr_issue_q
// Purpose : Small instruction queue in front of the control decoder. It
//           buffers 32-bit instruction words and presents the oldest one as
//           opcode/funct plus its PC under a valid/ready handshake. A flush
//           (taken branch) discards the queue, reloads the PC and inserts a
//           one-cycle bubble before issue resumes.
// Ports   :
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   producer offers in_instr this cycle
//   in_ready   queue accepts a word this cycle
//   in_instr   32-bit instruction word
//   out_valid  opc/funct/out_pc describe a valid instruction
//   out_ready  decoder consumes the presented instruction
//   opc        head word [31:26] (zero when nothing is presented)
//   funct      head word [5:0]   (zero when nothing is presented)
//   out_pc     PC of the head word
//   flush      discard queue, redirect to flush_pc
//   flush_pc   PC of the first word after the flush
//   count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module instr_issue_q #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 2,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [5:0]    opc,
    output logic [5:0]    funct,
    output logic [31:0]   out_pc,
    input  logic          flush,
    input  logic [31:0]   flush_pc,
    output logic [AW:0]   count
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

    state_t        state_r;
    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [31:0]   pc_r;

    logic [31:0]   head_s;
    logic          push_s;
    logic          pop_s;
    logic          unused_head_bits_s;

    assign head_s = mem_r[rd_ptr_r];
    // Middle bits of the word are buffered but not presented to the decoder.
    assign unused_head_bits_s = ^head_s[25:6];

    assign out_pc = pc_r;
    assign count  = count_r;

    // Handshake qualifiers and first-word fall-through presentation of the head.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        opc       = 6'd0;
        funct     = 6'd0;
        push_s    = 1'b0;
        pop_s     = 1'b0;

        // in_ready looks at occupancy only, so a full queue never accepts a
        // word even when the decoder is draining in the same cycle.
        if ((state_r == ST_RUN) && (count_r < FULL_CNT) && !flush) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end

        if ((state_r == ST_RUN) && (count_r != CNT_ZERO)) begin
            out_valid = 1'b1;
            opc       = head_s[31:26];
            funct     = head_s[5:0];
        end else begin
            // Masked so an empty queue or bubble never shows stale fields.
            out_valid = 1'b0;
            opc       = 6'd0;
            funct     = 6'd0;
        end

        push_s = in_valid & in_ready;
        pop_s  = out_valid & out_ready;
    end

    // Queue storage, pointers, occupancy, PC tracking and RUN/BUBBLE state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            pc_r     <= PC_RESET;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0;
            end
        end else if (flush) begin
            // Redirect wins over any push/pop offered in the same cycle.
            state_r  <= ST_BUBBLE;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            pc_r     <= flush_pc;
        end else begin
            state_r <= ST_RUN;

            if (push_s) begin
                mem_r[wr_ptr_r] <= in_instr;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                pc_r     <= pc_r + 32'd4;
            end else begin
                rd_ptr_r <= rd_ptr_r;
                pc_r     <= pc_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue_q.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_q
// Directed bench for instr_issue_q. A queue-based reference model tracks the
// buffered words, the head PC and the bubble cycle; it is compared against
// the DUT on every falling edge. Literal expectations at key points pin the
// model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_instr_issue_q;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opc;
    logic [5:0]  funct;
    logic [31:0] out_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pop_seen  = 0;

    // reference model state
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_bubble;
    bit          model_on = 1'b0;

    instr_issue_q #(.DEPTH(4), .AW(2), .PC_RESET(32'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .opc      (opc),
        .funct    (funct),
        .out_pc   (out_pc),
        .flush    (flush),
        .flush_pc (flush_pc),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare, then advance the model with the inputs the next edge samples.
    always @(negedge clk) begin
        bit          e_valid;
        bit          e_ready;
        bit          do_push;
        bit          do_pop;
        logic [31:0] head;
        e_valid = !m_bubble && (m_q.size() != 0);
        e_ready = !m_bubble && (m_q.size() < 4) && !flush;
        head    = e_valid ? m_q[0] : 32'h0;
        if (model_on) begin
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, e_valid});
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, e_ready});
            chk("m_count", {29'd0, count}, m_q.size());
            chk("m_opc", {26'd0, opc}, {26'd0, head[31:26]});
            chk("m_funct", {26'd0, funct}, {26'd0, head[5:0]});
            if (e_valid) chk("m_out_pc", out_pc, m_pc);
            if (e_valid && out_ready) pop_seen++;
        end
        if (!rst_n) begin
            m_q.delete();
            m_pc     = 32'h0;
            m_bubble = 1'b0;
            model_on = 1'b1;
        end else if (flush) begin
            m_q.delete();
            m_pc     = flush_pc;
            m_bubble = 1'b1;
        end else begin
            do_push  = in_valid && e_ready;
            do_pop   = e_valid && out_ready;
            m_bubble = 1'b0;
            if (do_pop) begin
                void'(m_q.pop_front());
                m_pc = m_pc + 32'd4;
            end
            if (do_push) m_q.push_back(in_instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkword(input int k);
        logic [31:0] w;
        logic [5:0]  f;
        f = 6'(k);
        w = {f, 20'(k * 7), ~f};
        return w;
    endfunction

    // Offer words k0..k0+n-1 in order, holding each until accepted.
    task automatic push_seq(input int k0, input int n, input int budget);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < budget) begin
            in_valid = 1'b1;
            in_instr = mkword(k0 + idx);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (idx != n) chk("push_budget", idx, n);
    endtask

    task automatic drain(input int budget);
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (count != 3'd0 && cyc < budget) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_empty", {29'd0, count}, 32'd0);
    endtask

    initial begin
        int accepted;
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
        flush = 1'b0; flush_pc = 32'h0;

        // reset held for two clocks
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_opc", {26'd0, opc}, 32'd0);
        tick();
        rst_n = 1'b1;

        // single issue of lw
        in_valid = 1'b1; in_instr = 32'h8C220004;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_opc", {26'd0, opc}, 32'h23);
        chk("single_funct", {26'd0, funct}, 32'h04);
        chk("single_pc", out_pc, 32'h0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("single_count", {29'd0, count}, 32'd0);
        chk("single_pc_adv", out_pc, 32'h4);
        tick();

        // fresh start so the fill sequence issues from PC 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // fill: five offered cycles, only four accepted
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = mkword(10 + accepted);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) accepted++;
        end
        @(negedge clk);
        chk("fill_accepted", accepted, 32'd4);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_head_opc", {26'd0, opc}, 32'd10);
        chk("fill_head_pc", out_pc, 32'h0);
        tick();
        // drain while the producer still holds the 5th word
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mkword(14);
        @(negedge clk);
        acc = in_ready;
        tick();
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        drain(20);
        chk("fill_final_pc", out_pc, 32'd20);

        // concurrent traffic from a full queue
        push_seq(20, 4, 10);
        pop_seen = 0;
        out_ready = 1'b1;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = mkword(24 + accepted);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) accepted++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("conc_pops", pop_seen, 32'd8);
        chk("conc_pushes", accepted, 32'd7);
        drain(20);

        // flush with three queued and a push in the same cycle
        push_seq(40, 3, 10);
        flush = 1'b1; flush_pc = 32'h40; in_valid = 1'b1; in_instr = mkword(50);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_bubble_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b1; in_instr = mkword(51);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_issue_valid", {31'd0, out_valid}, 32'd1);
        chk("flush_issue_pc", out_pc, 32'h40);
        tick();
        drain(10);

        // flush held over several cycles with changing target
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush_pc = 32'h100 + 32'(i * 16);
            in_valid = 1'b1;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        push_seq(60, 1, 5);
        @(negedge clk);
        chk("flush_hold_pc", out_pc, 32'h120);
        tick();
        drain(10);

        // PC wrap
        flush = 1'b1; flush_pc = 32'hFFFFFFFC;
        tick();
        flush = 1'b0;
        tick();
        push_seq(70, 2, 6);
        @(negedge clk);
        chk("wrap_pc0", out_pc, 32'hFFFFFFFC);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("wrap_pc1", out_pc, 32'h0);
        tick();
        drain(10);

        // mid-operation reset overrides flush and handshakes
        push_seq(80, 2, 6);
        rst_n = 1'b0; flush = 1'b1; flush_pc = 32'h200;
        in_valid = 1'b1; out_ready = 1'b1; in_instr = mkword(90);
        tick();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("mrst_count", {29'd0, count}, 32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_pc", out_pc, 32'h0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
